// File: rtl/triangle_project_scheduler_if.sv
// Output stream from the scheduler's in-order FIFO to the rasterizer.
// The scheduler drives the master side; the rasterizer holds the slave side.
interface triangle_project_scheduler_if #(
    parameter int ADDR_W = 12,
    parameter int TRI2_W = 48
);
    logic              out_valid;
    logic [TRI2_W-1:0] out_tri;
    logic [ADDR_W-1:0] out_idx;
    logic              out_ready;

    modport master (
        output out_valid,
        output out_tri,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_tri,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/triangle_project_scheduler.sv
// Frame sequencer: credit-limited reads from triangle memory into the projection pipe.
// Results land in an in-order FIFO. Define TRI_SCHED_STATS_EN to build the cycle/stall counters.
module triangle_project_scheduler #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int RD_LATENCY = 2,
    parameter int VIEW_W     = 64,
    parameter int TRI3_W     = 96,
    parameter int TRI2_W     = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [VIEW_W-1:0]            camera_in,
    input  logic [ADDR_W-1:0]            num_tris,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         tri_rd_en,
    output logic [ADDR_W-1:0]            tri_addr,
    input  logic [TRI3_W-1:0]            tri_rd_data,
    output logic [VIEW_W-1:0]            proj_camera,
    output logic                         proj_valid,
    output logic [TRI3_W-1:0]            proj_tri,
    input  logic [TRI2_W-1:0]            proj_out,
    input  logic                         proj_out_valid,
    triangle_project_scheduler_if.master out_if,
    output logic [31:0]                  frame_cycles,
    output logic [31:0]                  stall_cycles
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t              r_state;
    logic [VIEW_W-1:0]   r_camera;
    logic [ADDR_W-1:0]   r_num_tris;
    logic [ADDR_W-1:0]   r_issue_idx;
    logic [ADDR_W-1:0]   r_pop_cnt;
    logic [CNT_W-1:0]    r_credits;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [RD_LATENCY-1:0] r_rd_sr;

    logic [TRI2_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_out_valid;
    logic                w_pop;
    logic                w_push;
    logic [ADDR_W-1:0]   w_idx_next;
    logic [ADDR_W-1:0]   w_pop_next;
    logic [CNT_W-1:0]    w_credits_next;

    assign w_out_valid    = (r_count != '0);
    assign w_pop          = w_out_valid && out_if.out_ready;
    // Credits keep the FIFO from filling without a pop; the pop term only covers same-cycle swap.
    assign w_push         = proj_out_valid && (r_state != ST_IDLE) && ((r_count != DEPTH_C) || w_pop);
    assign w_idx_next     = r_issue_idx + ADDR_W'(r_rd_en);
    assign w_pop_next     = r_pop_cnt + ADDR_W'(w_pop);
    assign w_credits_next = r_credits - CNT_W'(r_rd_en) + CNT_W'(w_pop);

    // tri_rd_en is registered, so the next-cycle issue decision looks ahead at next credits/index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_camera     <= '0;
            r_num_tris   <= '0;
            r_issue_idx  <= '0;
            r_pop_cnt    <= '0;
            r_credits    <= DEPTH_C;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_credits    <= w_credits_next;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_camera    <= camera_in;
                        r_num_tris  <= num_tris;
                        r_issue_idx <= '0;
                        r_pop_cnt   <= '0;
                        if (num_tris == '0) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_rd_en <= (w_credits_next != '0);
                            r_addr  <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_issue_idx <= w_idx_next;
                    r_pop_cnt   <= w_pop_next;
                    if (w_idx_next == r_num_tris) begin
                        r_state <= ST_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_en <= (w_credits_next != '0);
                        r_addr  <= w_idx_next;
                    end
                end
                ST_DRAIN: begin
                    r_pop_cnt <= w_pop_next;
                    if (w_pop_next == r_num_tris) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sr <= '0;
        end else begin
            r_rd_sr[0] <= r_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_sr[i] <= r_rd_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= proj_out;
        end
    end

`ifdef TRI_SCHED_STATS_EN
    logic [31:0] r_frame_cycles;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cycles <= '0;
            r_stall_cycles <= '0;
        end else if (r_state == ST_IDLE) begin
            if (frame_start) begin
                r_frame_cycles <= '0;
                r_stall_cycles <= '0;
            end
        end else begin
            if (r_frame_cycles != '1) begin
                r_frame_cycles <= r_frame_cycles + 32'd1;
            end
            if (w_out_valid && !out_if.out_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign frame_cycles = r_frame_cycles;
    assign stall_cycles = r_stall_cycles;
`else
    assign frame_cycles = '0;
    assign stall_cycles = '0;
`endif

    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
    assign tri_rd_en      = r_rd_en;
    assign tri_addr       = r_addr;
    assign proj_camera    = r_camera;
    assign proj_valid     = r_rd_sr[RD_LATENCY-1];
    assign proj_tri       = tri_rd_data;
    assign out_if.out_valid = w_out_valid;
    assign out_if.out_tri   = r_mem[r_rd_ptr];
    assign out_if.out_idx   = r_pop_cnt;
endmodule

// File: tb/tb_triangle_project_scheduler.sv
// Bench for triangle_project_scheduler: memory and projection-pipe models feed a scoreboard
// that checks read order, output order/data, frame_done timing and the stats outputs.
module tb_triangle_project_scheduler;
    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 16;
    localparam int RD_LATENCY = 2;
    localparam int VIEW_W     = 64;
    localparam int TRI3_W     = 96;
    localparam int TRI2_W     = 48;
    localparam int PIPE_L     = 63;

    logic                clk = 1'b0;
    logic                rst;
    logic                frame_start;
    logic [VIEW_W-1:0]   camera_in;
    logic [ADDR_W-1:0]   num_tris;
    logic                busy;
    logic                frame_done;
    logic                tri_rd_en;
    logic [ADDR_W-1:0]   tri_addr;
    logic [TRI3_W-1:0]   tri_rd_data;
    logic [VIEW_W-1:0]   proj_camera;
    logic                proj_valid;
    logic [TRI3_W-1:0]   proj_tri;
    logic [TRI2_W-1:0]   proj_out;
    logic                proj_out_valid;
    logic [31:0]         frame_cycles;
    logic [31:0]         stall_cycles;
    logic                inj_valid;
    logic [TRI2_W-1:0]   inj_data;
    int                  ready_pct;

    triangle_project_scheduler_if #(.ADDR_W(ADDR_W), .TRI2_W(TRI2_W)) out_if ();

    triangle_project_scheduler #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LATENCY(RD_LATENCY),
        .VIEW_W(VIEW_W), .TRI3_W(TRI3_W), .TRI2_W(TRI2_W)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .camera_in(camera_in),
        .num_tris(num_tris), .busy(busy), .frame_done(frame_done),
        .tri_rd_en(tri_rd_en), .tri_addr(tri_addr), .tri_rd_data(tri_rd_data),
        .proj_camera(proj_camera), .proj_valid(proj_valid), .proj_tri(proj_tri),
        .proj_out(proj_out), .proj_out_valid(proj_out_valid), .out_if(out_if),
        .frame_cycles(frame_cycles), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [TRI3_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {20'hA5A5A, a, 20'h3C3C3, a ^ 12'h5A5, 20'hDEAD0, a};
    endfunction

    function automatic logic [TRI2_W-1:0] proj_fn(input logic [TRI3_W-1:0] t);
        return t[95:48] ^ {t[23:0], t[47:24]};
    endfunction

    // Triangle memory with a two-cycle read; idle cycles return zero.
    logic [TRI3_W-1:0] rd_d1, rd_d2;
    always @(posedge clk) begin
        rd_d1 <= tri_rd_en ? mem_word(tri_addr) : '0;
        rd_d2 <= rd_d1;
    end
    assign tri_rd_data = rd_d2;

    // Projection pipeline model with fixed latency, flushed by reset.
    logic              pv [PIPE_L];
    logic [TRI2_W-1:0] pd [PIPE_L];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_L; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= proj_valid;
            pd[0] <= proj_fn(proj_tri);
            for (int i = 1; i < PIPE_L; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign proj_out_valid = pv[PIPE_L-1] | inj_valid;
    assign proj_out       = inj_valid ? inj_data : pd[PIPE_L-1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [TRI2_W-1:0] tri_v;
    } exp_t;

    exp_t sb_q[$];
    int   exp_issue = 0;
    int   cyc = 0;
    int   reads_total = 0;
    int   pops_total = 0;
    int   done_total = 0;
    int   last_pop_cyc = 0;
    int   stall_cnt = 0;
    int   busy_cnt = 0;
    int   mon_num = 0;

    // Scoreboard: expectations pushed on each read issue, popped on each output handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (rst) begin
            sb_q.delete();
            exp_issue = 0;
        end else begin
            if (frame_start && !busy) begin
                exp_issue = 0;
                stall_cnt = 0;
                busy_cnt  = 0;
                mon_num   = int'(num_tris);
            end
            if (busy) busy_cnt++;
            if (tri_rd_en) begin
                check("rd_addr", tri_addr, exp_issue);
                e.idx   = ADDR_W'(exp_issue);
                e.tri_v = proj_fn(mem_word(e.idx));
                sb_q.push_back(e);
                exp_issue++;
                reads_total++;
            end
            if (out_if.out_valid && !out_if.out_ready) stall_cnt++;
            if (out_if.out_valid && out_if.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_with_empty_scoreboard", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_idx", out_if.out_idx, e.idx);
                    check("out_tri", out_if.out_tri, e.tri_v);
                    $display("pop idx=%0d tri=%0h", out_if.out_idx, out_if.out_tri);
                end
                pops_total++;
                last_pop_cyc = cyc;
            end
            if (frame_done) begin
                done_total++;
                check("done_busy_low", busy, 0);
                if (mon_num != 0) check("done_after_last_pop", cyc, last_pop_cyc + 1);
            end
        end
    end

    initial begin
        out_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_if.out_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input int n, input logic [VIEW_W-1:0] cam);
        @(posedge clk); #1;
        frame_start = 1'b1;
        num_tris    = ADDR_W'(n);
        camera_in   = cam;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_total;
        n  = 0;
        while (done_total == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_frame_done_seen"}, done_total - d0, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_frame_done"}, frame_done, 0);
        check({name, "_tri_rd_en"}, tri_rd_en, 0);
        check({name, "_proj_valid"}, proj_valid, 0);
        check({name, "_out_valid"}, out_if.out_valid, 0);
        check({name, "_tri_addr"}, tri_addr, 0);
        check({name, "_out_idx"}, out_if.out_idx, 0);
        check({name, "_proj_camera"}, proj_camera, 0);
    endtask

    task automatic check_stats(input string name);
`ifdef TRI_SCHED_STATS_EN
        check({name, "_stall_cycles"}, stall_cycles, stall_cnt);
        check({name, "_frame_cycles"}, frame_cycles, busy_cnt);
`else
        check({name, "_stall_cycles_tied"}, stall_cycles, 0);
        check({name, "_frame_cycles_tied"}, frame_cycles, 0);
`endif
    endtask

    typedef struct {
        int num;
        int pct;
        int exp_reads;
        int exp_pops;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   r0, p0, d0;
        logic [VIEW_W-1:0] cam;

        vecs[0] = '{5, 100, 5, 5};
        vecs[1] = '{1, 100, 1, 1};
        vecs[2] = '{17, 100, 17, 17};
        vecs[3] = '{20, 50, 20, 20};
        vecs[4] = '{3, 30, 3, 3};

        rst = 1'b1; frame_start = 1'b0; camera_in = '0; num_tris = '0;
        inj_valid = 1'b0; inj_data = '0; ready_pct = 100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // First frame: cycle-exact start of issue and of the read-valid delay.
        start_frame(5, 64'h1111_2222_3333_4444);
        @(negedge clk);
        check("c1_busy", busy, 1);
        check("c1_tri_rd_en", tri_rd_en, 1);
        check("c1_proj_valid", proj_valid, 0);
        check("c1_proj_camera", proj_camera, 64'h1111_2222_3333_4444);
        @(negedge clk);
        check("c2_proj_valid", proj_valid, 0);
        @(negedge clk);
        check("c3_proj_valid", proj_valid, 1);
        check("c3_proj_tri", proj_tri, mem_word(12'd0));
        wait_done(2000, "first");
        $display("frame num=5 reads=%0d pops=%0d", reads_total, pops_total);
        check("first_reads", reads_total, 5);
        check("first_pops", pops_total, 5);

        // Table of frames with varying size and downstream readiness.
        for (int v = 0; v < 5; v++) begin
            ready_pct = vecs[v].pct;
            r0 = reads_total; p0 = pops_total; d0 = done_total;
            cam = {32'hCAFE0000, 32'(v)};
            start_frame(vecs[v].num, cam);
            wait_done(3000, "vec");
            repeat (2) @(negedge clk);
            $display("frame num=%0d ready_pct=%0d reads=%0d pops=%0d",
                     vecs[v].num, vecs[v].pct, reads_total - r0, pops_total - p0);
            check("vec_reads", reads_total - r0, vecs[v].exp_reads);
            check("vec_pops", pops_total - p0, vecs[v].exp_pops);
            check("vec_done_count", done_total - d0, 1);
            check("vec_sb_empty", sb_q.size(), 0);
            check("vec_camera", proj_camera, cam);
            check_stats("vec");
        end
        ready_pct = 100;

        // Zero-triangle frame.
        r0 = reads_total;
        start_frame(0, 64'h0BAD_F00D_0000_0001);
        @(negedge clk);
        check("zero_frame_done_c1", frame_done, 1);
        check("zero_busy_c1", busy, 0);
        check("zero_camera", proj_camera, 64'h0BAD_F00D_0000_0001);
        @(negedge clk);
        check("zero_frame_done_c2", frame_done, 0);
        repeat (5) @(negedge clk);
        check("zero_reads", reads_total - r0, 0);
        check("zero_busy_later", busy, 0);
        $display("frame num=0 reads=%0d", reads_total - r0);

        // Projection output arriving while idle must be dropped.
        @(posedge clk); #1;
        inj_valid = 1'b1; inj_data = 48'h123456789ABC;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        @(negedge clk);
        check("idle_push_dropped", out_if.out_valid, 0);

        // Downstream stalled: credits cap issue at FIFO_DEPTH; a busy frame_start is ignored.
        ready_pct = 0;
        @(posedge clk);
        r0 = reads_total; p0 = pops_total;
        start_frame(40, 64'h3333_0000_0000_0003);
        repeat (50) @(posedge clk);
        #1;
        camera_in = 64'h4444_0000_0000_0004; num_tris = 12'd7; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (150) @(negedge clk);
        $display("stall reads=%0d out_valid=%0b", reads_total - r0, out_if.out_valid);
        check("stall_reads", reads_total - r0, FIFO_DEPTH);
        check("stall_out_valid", out_if.out_valid, 1);
        check("stall_busy", busy, 1);
        check("stall_camera_held", proj_camera, 64'h3333_0000_0000_0003);
        ready_pct = 100;
        wait_done(3000, "stall");
        repeat (2) @(negedge clk);
        check("stall_all_reads", reads_total - r0, 40);
        check("stall_all_pops", pops_total - p0, 40);
        check("stall_camera_after", proj_camera, 64'h3333_0000_0000_0003);
        check("stall_sb_empty", sb_q.size(), 0);
        check_stats("stall");

        // Reset at cycle 30 of a 20-triangle frame.
        d0 = done_total;
        start_frame(20, 64'h5555_0000_0000_0005);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        repeat (100) @(negedge clk);
        check("midreset_no_done", done_total - d0, 0);
        check("midreset_idle_out_valid", out_if.out_valid, 0);
        r0 = reads_total; p0 = pops_total;
        start_frame(5, 64'h6666_0000_0000_0006);
        wait_done(2000, "after_reset");
        repeat (2) @(negedge clk);
        $display("frame after reset reads=%0d pops=%0d", reads_total - r0, pops_total - p0);
        check("after_reset_reads", reads_total - r0, 5);
        check("after_reset_pops", pops_total - p0, 5);
        check("after_reset_camera", proj_camera, 64'h6666_0000_0000_0006);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
